// File: rtl/draw_cmd_scheduler_if.sv
// Command, issue and status signals between the draw-command decoder/GPU side
// and the draw command scheduler.
interface draw_cmd_scheduler_if;
   logic       in_valid;
   logic [1:0] in_cmd;
   logic [2:0] in_x1;
   logic [2:0] in_y1;
   logic [2:0] in_x2;
   logic [2:0] in_y2;
   logic [2:0] in_w;
   logic [2:0] in_h;
   logic       in_ready;

   logic       out_valid;
   logic [1:0] out_cmd;
   logic [2:0] out_x1;
   logic [2:0] out_y1;
   logic [2:0] out_x2;
   logic [2:0] out_y2;
   logic [2:0] out_w;
   logic [2:0] out_h;

   logic       gpu_done;
   logic       frame_start;
   logic       flush;

   logic [2:0] count;
   logic       busy;
   logic       overflow;
   logic       timeout_err;

   modport master (
      output in_valid, in_cmd, in_x1, in_y1, in_x2, in_y2, in_w, in_h,
      output gpu_done, frame_start, flush,
      input  in_ready, out_valid, out_cmd, out_x1, out_y1, out_x2, out_y2, out_w, out_h,
      input  count, busy, overflow, timeout_err
   );

   modport slave (
      input  in_valid, in_cmd, in_x1, in_y1, in_x2, in_y2, in_w, in_h,
      input  gpu_done, frame_start, flush,
      output in_ready, out_valid, out_cmd, out_x1, out_y1, out_x2, out_y2, out_w, out_h,
      output count, busy, overflow, timeout_err
   );
endinterface

// File: rtl/draw_cmd_scheduler.sv
// Queues decoded draw commands in a 4-deep FIFO and issues them one at a time to
// the graphics processor, holding CLEAR commands until the next frame boundary.
module draw_cmd_scheduler #(
   parameter int TIMEOUT = 200
) (
   input  logic                 clk,
   input  logic                 rst_n,
   draw_cmd_scheduler_if.slave  bus
);

   typedef enum logic [1:0] {
      IDLE,
      WAIT_FRAME,
      ISSUE,
      BUSY
   } state_t;

   localparam logic [7:0] TIMER_LAST = 8'(TIMEOUT - 1);
   localparam logic [1:0] CMD_CLEAR  = 2'b00;

   state_t      state;
   state_t      state_nxt;
   logic [19:0] mem [4];
   logic [1:0]  wr_ptr;
   logic [1:0]  rd_ptr;
   logic [2:0]  count;
   logic [7:0]  timer;
   logic        overflow;
   logic        timeout_err;
   logic [19:0] out_word;

   logic [19:0] in_word;
   logic [19:0] head;
   logic        in_ready;
   logic        push;
   logic        pop;
   logic        drop;
   logic        timeout_hit;

   assign in_word  = {bus.in_cmd, bus.in_x1, bus.in_y1, bus.in_x2, bus.in_y2, bus.in_w, bus.in_h};
   assign head     = mem[rd_ptr];
   assign in_ready = (count < 3'd4);

   // A command arriving in a flush cycle is discarded silently, never counted as overflow.
   assign push        = bus.in_valid && in_ready && !bus.flush;
   assign drop        = bus.in_valid && !in_ready && !bus.flush;
   assign pop         = (state == ISSUE);
   assign timeout_hit = (state == BUSY) && !bus.gpu_done && (timer == TIMER_LAST);

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE: begin
            if (count != 3'd0) begin
               if (head[19:18] == CMD_CLEAR) state_nxt = WAIT_FRAME;
               else                          state_nxt = ISSUE;
            end
         end
         WAIT_FRAME: begin
            if (bus.frame_start) state_nxt = ISSUE;
         end
         ISSUE: begin
            state_nxt = BUSY;
         end
         BUSY: begin
            if (bus.gpu_done || (timer == TIMER_LAST)) state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
      if (bus.flush) state_nxt = IDLE;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         wr_ptr      <= 2'd0;
         rd_ptr      <= 2'd0;
         count       <= 3'd0;
         timer       <= 8'd0;
         overflow    <= 1'b0;
         timeout_err <= 1'b0;
         out_word    <= 20'd0;
      end else begin
         state <= state_nxt;
         if (bus.flush) begin
            wr_ptr      <= 2'd0;
            rd_ptr      <= 2'd0;
            count       <= 3'd0;
            overflow    <= 1'b0;
            timeout_err <= 1'b0;
         end else begin
            if (push) wr_ptr <= wr_ptr + 2'd1;
            if (pop)  rd_ptr <= rd_ptr + 2'd1;
            unique case ({push, pop})
               2'b10:   count <= count + 3'd1;
               2'b01:   count <= count - 3'd1;
               default: count <= count;
            endcase
            if (drop)        overflow    <= 1'b1;
            if (timeout_hit) timeout_err <= 1'b1;
         end
         // The ISSUE cycle doubles as the timer clear so BUSY always starts at zero.
         if (state == ISSUE)     timer <= 8'd0;
         else if (state == BUSY) timer <= timer + 8'd1;
         if (state_nxt == ISSUE) out_word <= head;
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= in_word;
   end

   assign bus.in_ready    = in_ready;
   assign bus.out_valid   = (state == ISSUE);
   assign bus.out_cmd     = out_word[19:18];
   assign bus.out_x1      = out_word[17:15];
   assign bus.out_y1      = out_word[14:12];
   assign bus.out_x2      = out_word[11:9];
   assign bus.out_y2      = out_word[8:6];
   assign bus.out_w       = out_word[5:3];
   assign bus.out_h       = out_word[2:0];
   assign bus.count       = count;
   assign bus.busy        = (state != IDLE);
   assign bus.overflow    = overflow;
   assign bus.timeout_err = timeout_err;

endmodule

// File: tb/tb_draw_cmd_scheduler.sv
// Directed bench for draw_cmd_scheduler: expected issues go into a scoreboard queue,
// a negedge monitor pops and compares them whenever out_valid is seen.
module tb_draw_cmd_scheduler;

   typedef struct {
      logic [19:0] word;
      int          cyc;
   } exp_t;

   logic clk;
   logic rst_n;
   int   cyc;
   int   checks;
   int   errors;
   exp_t sb [$];

   draw_cmd_scheduler_if bus ();

   draw_cmd_scheduler #(.TIMEOUT(8)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [19:0] pack(input logic [1:0] c, input logic [2:0] x1, input logic [2:0] y1,
                                        input logic [2:0] x2, input logic [2:0] y2, input logic [2:0] w,
                                        input logic [2:0] h);
      return {c, x1, y1, x2, y2, w, h};
   endfunction

   function automatic logic [19:0] out_word();
      return {bus.out_cmd, bus.out_x1, bus.out_y1, bus.out_x2, bus.out_y2, bus.out_w, bus.out_h};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s at cyc %0d: actual=%0h required=%0h", name, cyc, act, req);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Drives one command for one cycle; exp_cyc < 0 means the issue cycle is not pinned.
   task automatic send(input logic [1:0] c, input logic [2:0] x1, input logic [2:0] y1,
                       input logic [2:0] x2, input logic [2:0] y2, input logic [2:0] w,
                       input logic [2:0] h, input bit expect_issue, input int exp_cyc);
      exp_t e;
      bus.in_valid = 1'b1;
      bus.in_cmd   = c;
      bus.in_x1    = x1;
      bus.in_y1    = y1;
      bus.in_x2    = x2;
      bus.in_y2    = y2;
      bus.in_w     = w;
      bus.in_h     = h;
      if (expect_issue) begin
         e.word = pack(c, x1, y1, x2, y2, w, h);
         e.cyc  = exp_cyc;
         sb.push_back(e);
      end
      @(negedge clk);
      bus.in_valid = 1'b0;
   endtask

   task automatic pulse_done();
      bus.gpu_done = 1'b1;
      @(negedge clk);
      bus.gpu_done = 1'b0;
   endtask

   task automatic pulse_flush();
      bus.flush = 1'b1;
      @(negedge clk);
      bus.flush = 1'b0;
   endtask

   always @(negedge clk) begin : monitor
      exp_t e;
      if (bus.out_valid === 1'b1) begin
         checks++;
         if (sb.size() == 0) begin
            errors++;
            $display("FAIL unexpected_issue at cyc %0d: actual=%05h required=no issue", cyc, out_word());
         end else begin
            e = sb.pop_front();
            if (out_word() !== e.word || (e.cyc >= 0 && e.cyc != cyc)) begin
               errors++;
               $display("FAIL issue at cyc %0d: actual=%05h required=%05h at cyc %0d",
                        cyc, out_word(), e.word, e.cyc);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int k;
      checks          = 0;
      errors          = 0;
      rst_n           = 1'b0;
      bus.in_valid    = 1'b0;
      bus.in_cmd      = 2'd0;
      bus.in_x1       = 3'd0;
      bus.in_y1       = 3'd0;
      bus.in_x2       = 3'd0;
      bus.in_y2       = 3'd0;
      bus.in_w        = 3'd0;
      bus.in_h        = 3'd0;
      bus.gpu_done    = 1'b0;
      bus.frame_start = 1'b0;
      bus.flush       = 1'b0;

      // Reset values
      step(2);
      chk("rst_count", 32'(bus.count), 0);
      chk("rst_in_ready", 32'(bus.in_ready), 1);
      chk("rst_busy", 32'(bus.busy), 0);
      chk("rst_out_valid", 32'(bus.out_valid), 0);
      chk("rst_out_fields", 32'(out_word()), 0);
      chk("rst_flags", 32'({bus.overflow, bus.timeout_err}), 0);
      rst_n = 1'b1;
      step(2);

      // Single draw: issue at N+2, busy until gpu_done
      k = cyc;
      send(2'b01, 3'd1, 3'd2, 3'd5, 3'd6, 3'd3, 3'd4, 1'b1, k + 2);
      chk("draw_count_q", 32'(bus.count), 1);
      chk("draw_idle_busy", 32'(bus.busy), 0);
      step(1);
      chk("draw_issue_busy", 32'(bus.busy), 1);
      step(1);
      chk("draw_popped", 32'(bus.count), 0);
      step(3);
      pulse_done();
      chk("draw_done_idle", 32'(bus.busy), 0);
      chk("draw_no_timeout", 32'(bus.timeout_err), 0);
      chk("draw_out_held", 32'(out_word()), 32'(pack(2'b01, 3'd1, 3'd2, 3'd5, 3'd6, 3'd3, 3'd4)));
      step(2);

      // CLEAR waits for frame_start; stray gpu_done in WAIT_FRAME is ignored
      k = cyc;
      send(2'b00, 3'd0, 3'd0, 3'd7, 3'd7, 3'd7, 3'd7, 1'b1, k + 11);
      step(1);
      chk("clear_wait_busy", 32'(bus.busy), 1);
      step(3);
      pulse_done();
      chk("clear_still_wait", 32'(bus.busy), 1);
      step(4);
      bus.frame_start = 1'b1;
      step(1);
      bus.frame_start = 1'b0;
      step(1);
      pulse_done();
      chk("clear_done_idle", 32'(bus.busy), 0);
      step(2);

      // Fill while BUSY: four queued, fifth dropped, then in-order issue
      k = cyc;
      send(2'b01, 3'd7, 3'd0, 3'd3, 3'd3, 3'd1, 3'd1, 1'b1, k + 2);
      step(2);
      for (int i = 1; i <= 5; i++) begin
         send(2'((i % 3) + 1), 3'(i), 3'(i + 1), 3'(7 - i), 3'(2 * i), 3'(i + 3), 3'(5 - i),
              i <= 4, k + 10 + 4 * (i - 1));
      end
      chk("full_count", 32'(bus.count), 4);
      chk("full_in_ready", 32'(bus.in_ready), 0);
      chk("full_overflow", 32'(bus.overflow), 1);
      for (int j = 0; j < 4; j++) begin
         pulse_done();
         step(3);
      end
      pulse_done();
      chk("drain_count", 32'(bus.count), 0);
      chk("drain_idle", 32'(bus.busy), 0);
      chk("overflow_sticky", 32'(bus.overflow), 1);
      pulse_flush();
      chk("flush_clr_overflow", 32'(bus.overflow), 0);
      step(1);

      // Timeout after 8 BUSY cycles
      k = cyc;
      send(2'b10, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 1'b1, k + 2);
      step(9);
      chk("to_last_busy", 32'(bus.busy), 1);
      chk("to_not_yet", 32'(bus.timeout_err), 0);
      step(1);
      chk("to_idle", 32'(bus.busy), 0);
      chk("to_err_set", 32'(bus.timeout_err), 1);
      pulse_flush();
      chk("flush_clr_timeout", 32'(bus.timeout_err), 0);
      step(1);

      // gpu_done on the 8th BUSY cycle beats the timeout
      k = cyc;
      send(2'b11, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 1'b1, k + 2);
      step(9);
      pulse_done();
      chk("done_wins_idle", 32'(bus.busy), 0);
      chk("done_wins_no_err", 32'(bus.timeout_err), 0);
      step(1);

      // Flush during ISSUE: pulse still seen, no BUSY afterwards
      k = cyc;
      send(2'b01, 3'd3, 3'd3, 3'd3, 3'd3, 3'd3, 3'd3, 1'b1, k + 2);
      step(1);
      pulse_flush();
      chk("issue_flush_idle", 32'(bus.busy), 0);
      step(1);
      chk("issue_flush_stay", 32'(bus.busy), 0);

      // Three queued then flush with in_valid: everything discarded
      k = cyc;
      send(2'b01, 3'd1, 3'd1, 3'd1, 3'd1, 3'd1, 3'd1, 1'b1, k + 2);
      step(2);
      for (int i = 0; i < 3; i++) send(2'b10, 3'(i), 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 1'b0, -1);
      chk("pre_flush_count", 32'(bus.count), 3);
      bus.in_valid = 1'b1;
      bus.in_cmd   = 2'b01;
      pulse_flush();
      bus.in_valid = 1'b0;
      chk("flush_count", 32'(bus.count), 0);
      chk("flush_flags", 32'({bus.overflow, bus.timeout_err}), 0);
      chk("flush_idle", 32'(bus.busy), 0);
      chk("flush_in_ready", 32'(bus.in_ready), 1);
      step(12);

      // Reset during BUSY with commands queued
      k = cyc;
      send(2'b10, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd7, 1'b1, k + 2);
      step(2);
      send(2'b01, 3'd7, 3'd7, 3'd7, 3'd7, 3'd7, 3'd7, 1'b0, -1);
      send(2'b11, 3'd6, 3'd6, 3'd6, 3'd6, 3'd6, 3'd6, 1'b0, -1);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_count", 32'(bus.count), 0);
      chk("mid_rst_busy", 32'(bus.busy), 0);
      chk("mid_rst_in_ready", 32'(bus.in_ready), 1);
      chk("mid_rst_out_valid", 32'(bus.out_valid), 0);
      chk("mid_rst_out_fields", 32'(out_word()), 0);
      @(negedge clk);
      rst_n = 1'b1;
      step(12);
      chk("post_rst_idle", 32'(bus.busy), 0);
      chk("scoreboard_empty", 32'(sb.size()), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/draw_cmd_scheduler.md
DRAW_CMD_SCHEDULER -- requirements
Module: draw_cmd_scheduler

Interface
REQ-001 SHALL have parameter TIMEOUT, default 200, meaning the maximum number of cycles in BUSY waiting for gpu_done (range 1..255).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port in_valid  input  1  decoded draw command present this cycle.
REQ-005 SHALL have port in_cmd  input  2  opcode; 2'b00 = CLEAR, others = draw.
REQ-006 SHALL have port in_x1, in_y1, in_x2, in_y2, in_w, in_h  input  3 each  command coordinates and rectangle size.
REQ-007 SHALL have port in_ready  output  1  FIFO can accept a command this cycle.
REQ-008 SHALL have port out_valid  output  1  one-cycle issue strobe to the graphics processor.
REQ-009 SHALL have port out_cmd  output  2, and out_x1, out_y1, out_x2, out_y2, out_w, out_h  output  3 each  issued command fields.
REQ-010 SHALL have port gpu_done  input  1  graphics processor finished the current command.
REQ-011 SHALL have port frame_start  input  1  one-cycle frame boundary pulse.
REQ-012 SHALL have port flush  input  1  synchronous queue flush and error clear.
REQ-013 SHALL have port count  output  3  FIFO occupancy, 0..4.
REQ-014 SHALL have port busy  output  1  state is not IDLE.
REQ-015 SHALL have port overflow  output  1  sticky: a command was dropped because the FIFO was full.
REQ-016 SHALL have port timeout_err  output  1  sticky: gpu_done did not arrive within TIMEOUT cycles.

Function
REQ-017 SHALL buffer commands in a 4-entry FIFO of 20-bit entries {cmd, x1, y1, x2, y2, w, h}, issued in arrival order.
REQ-018 SHALL drive in_ready = (count < 4), derived from registered count only.
REQ-019 SHALL push when in_valid && in_ready; when in_valid && !in_ready, the command SHALL be dropped and overflow set.
REQ-020 SHALL accept a push in the same cycle as a pop only if count < 4 at the start of that cycle; count then stays unchanged.
REQ-021 SHALL implement FSM states IDLE, WAIT_FRAME, ISSUE, BUSY.
REQ-022 In IDLE with count > 0, SHALL move to WAIT_FRAME if the head cmd == 2'b00, else to ISSUE.
REQ-023 In WAIT_FRAME, SHALL move to ISSUE on the cycle frame_start is sampled high, and wait indefinitely otherwise.
REQ-024 In ISSUE, SHALL assert out_valid for exactly one cycle with the out_* fields equal to the head entry, pop the head, and move to BUSY.
REQ-025 out_* fields SHALL hold the last issued values when out_valid is low.
REQ-026 In BUSY, SHALL clear an 8-bit timer on entry and increment it each cycle.
REQ-027 In BUSY, on gpu_done SHALL move to IDLE; when the timer reaches TIMEOUT-1 without gpu_done, SHALL move to IDLE and set timeout_err.
REQ-028 If gpu_done coincides with the timeout cycle, gpu_done SHALL win and timeout_err SHALL remain unchanged.
REQ-029 gpu_done outside BUSY and frame_start outside WAIT_FRAME SHALL be ignored.
REQ-030 Latency: a command accepted into an empty FIFO while IDLE at cycle N SHALL give out_valid at cycle N+2 for draw opcodes; for CLEAR, it SHALL give out_valid one cycle after the first frame_start sampled in WAIT_FRAME.
REQ-031 flush SHALL empty the FIFO, clear overflow and timeout_err, and force IDLE next cycle from any state; a command presented with in_valid in the flush cycle SHALL be discarded without setting overflow.
REQ-032 A flush during the ISSUE cycle SHALL still let that cycle's out_valid pulse occur, but the FSM SHALL go to IDLE, not BUSY.
REQ-033 busy SHALL be high in WAIT_FRAME, ISSUE and BUSY.

Reset
REQ-034 On rst_n low, asynchronously: state = IDLE, count = 0, FIFO pointers = 0, timer = 0, out_valid = 0, all out_* fields = 0, overflow = 0, timeout_err = 0, busy = 0, in_ready = 1.
REQ-035 Reset asserted mid-operation SHALL discard all queued and in-flight commands; no out_valid SHALL occur until a new command is accepted after reset release.

Verification
REQ-036 Draw cmd=2'b01, x1=1, y1=2, x2=5, y2=6 pushed at cycle N while idle -> out_valid at N+2 with identical fields; busy until gpu_done; then IDLE.
REQ-037 CLEAR pushed, frame_start pulsed 10 cycles later -> out_valid exactly one cycle after frame_start, not before.
REQ-038 Five draw cmds pushed back-to-back while BUSY with no gpu_done -> count=4, in_ready=0, fifth dropped, overflow=1; then four issues in order as gpu_done returns.
REQ-039 TIMEOUT=8, issue without gpu_done -> return to IDLE after 8 BUSY cycles, timeout_err=1; gpu_done on the 8th BUSY cycle -> timeout_err stays 0.
REQ-040 Three cmds queued, flush asserted together with in_valid -> count=0, flags cleared, no further out_valid; rst_n pulsed during BUSY -> all outputs at reset values.
